dallanma_ongorucu: RTL and testbench

Branch predictor for the fetch stage, and the consumer of the execute stage's `g2_*` branch-feedback interface. It holds a direct-mapped table in which each entry has a valid bit, a tag, a target PC and a 2-bit saturating counter. Fetch issues a lookup with its PC and receives a registered taken/target prediction one cycle later. Execute writes resolved-branch outcomes back through the `g2_*` update port, and the block keeps running counts of predictions and mispredictions.

---
 rtl/dallanma_ongorucu.sv | 106 ++++++++++
 tb/tb_dallanma_ongorucu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dallanma_ongorucu.sv
// Direct-mapped branch predictor. Fetch lookups are answered one cycle later from
// a tag/target/2-bit-counter table, which the execute-stage g2_* port trains.
module dallanma_ongorucu #(
  parameter int PS_BIT    = 32,
  parameter int SATIR     = 64,
  parameter int SAYAC_BIT = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ongoru_istek_i,
  input  logic [PS_BIT-1:0]    ongoru_ps_i,
  input  logic                 ongoru_duraklat_i,
  input  logic                 ongoru_bosalt_i,
  output logic                 ongoru_gecerli_o,
  output logic [PS_BIT-1:0]    ongoru_ps_o,
  output logic                 ongoru_atla_o,
  output logic [PS_BIT-1:0]    ongoru_hedef_o,
  input  logic [PS_BIT-1:0]    g2_ps_i,
  input  logic                 g2_guncelle_i,
  input  logic                 g2_atladi_i,
  input  logic                 g2_hatali_tahmin_i,
  input  logic [PS_BIT-1:0]    g2_hedef_i,
  output logic [SAYAC_BIT-1:0] sayac_guncelle_o,
  output logic [SAYAC_BIT-1:0] sayac_hatali_o
);
  localparam int IDX     = $clog2(SATIR);
  localparam int TAG_BIT = PS_BIT - IDX - 2;

  logic [SATIR-1:0]       gecerli_tab;
  logic [SATIR-1:0][1:0]  sayac_tab;
  logic [TAG_BIT-1:0]     etiket_tab [SATIR];
  logic [PS_BIT-1:0]      hedef_tab  [SATIR];

  logic [IDX-1:0]     l_idx, u_idx;
  logic [TAG_BIT-1:0] l_tag, u_tag;
  logic               l_hit, l_atla, u_hit;
  logic [PS_BIT-1:0]  l_hedef;
  logic               unused_ps_bits;

  assign unused_ps_bits = ^{ongoru_ps_i[1:0], g2_ps_i[1:0]};

  // Lookup reads the table as it stood before this edge's update (read-old).
  assign l_idx   = ongoru_ps_i[IDX+1:2];
  assign l_tag   = ongoru_ps_i[PS_BIT-1:IDX+2];
  assign l_hit   = gecerli_tab[l_idx] && (etiket_tab[l_idx] == l_tag);
  assign l_atla  = l_hit && sayac_tab[l_idx][1];
  assign l_hedef = l_atla ? hedef_tab[l_idx] : ongoru_ps_i + PS_BIT'(4);

  assign u_idx = g2_ps_i[IDX+1:2];
  assign u_tag = g2_ps_i[PS_BIT-1:IDX+2];
  assign u_hit = gecerli_tab[u_idx] && (etiket_tab[u_idx] == u_tag);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ongoru_gecerli_o <= 1'b0;
      ongoru_ps_o      <= '0;
      ongoru_atla_o    <= 1'b0;
      ongoru_hedef_o   <= '0;
    end else if (ongoru_bosalt_i) begin
      ongoru_gecerli_o <= 1'b0;
    end else if (!ongoru_duraklat_i) begin
      ongoru_gecerli_o <= ongoru_istek_i;
      if (ongoru_istek_i) begin
        ongoru_ps_o    <= ongoru_ps_i;
        ongoru_atla_o  <= l_atla;
        ongoru_hedef_o <= l_hedef;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gecerli_tab <= '0;
      for (int i = 0; i < SATIR; i++) sayac_tab[i] <= 2'b01;
    end else if (g2_guncelle_i) begin
      if (u_hit) begin
        if (g2_atladi_i && sayac_tab[u_idx] != 2'b11)
          sayac_tab[u_idx] <= sayac_tab[u_idx] + 2'b01;
        else if (!g2_atladi_i && sayac_tab[u_idx] != 2'b00)
          sayac_tab[u_idx] <= sayac_tab[u_idx] - 2'b01;
      end else if (g2_atladi_i) begin
        gecerli_tab[u_idx] <= 1'b1;
        sayac_tab[u_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target need no reset; a cleared valid bit masks them. On a taken
  // hit the tag rewrite is a no-op, so both cases share one write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && g2_guncelle_i && g2_atladi_i) begin
      etiket_tab[u_idx] <= u_tag;
      hedef_tab[u_idx]  <= g2_hedef_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sayac_guncelle_o <= '0;
      sayac_hatali_o   <= '0;
    end else if (g2_guncelle_i) begin
      sayac_guncelle_o <= sayac_guncelle_o + SAYAC_BIT'(1);
      if (g2_hatali_tahmin_i) sayac_hatali_o <= sayac_hatali_o + SAYAC_BIT'(1);
    end
  end
endmodule

// File: tb/tb_dallanma_ongorucu.sv
// Directed and randomized checks of dallanma_ongorucu against a table model
// indexed with plain arithmetic on the PC.
module tb_dallanma_ongorucu;
  logic        clk = 1'b0, rst = 1'b0;
  logic        istek = 0, durak = 0, bosalt = 0;
  logic [31:0] ps = 0;
  logic        gecerli, atla;
  logic [31:0] ps_o, hedef;
  logic [31:0] g2_ps = 0, g2_hedef = 0;
  logic        g2_gun = 0, g2_atl = 0, g2_hat = 0;
  logic [31:0] s_gun, s_hat;

  int ntest = 0, nfail = 0;

  // Model: entry n holds PCs with (pc/4)%64 == n, tag is pc/256.
  bit          m_v   [64];
  int unsigned m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_ctr [64];
  bit          e_g, e_at;
  logic [31:0] e_ps, e_hd, e_cg, e_ch;

  dallanma_ongorucu dut (
    .clk_i(clk), .rst_i(rst),
    .ongoru_istek_i(istek), .ongoru_ps_i(ps),
    .ongoru_duraklat_i(durak), .ongoru_bosalt_i(bosalt),
    .ongoru_gecerli_o(gecerli), .ongoru_ps_o(ps_o),
    .ongoru_atla_o(atla), .ongoru_hedef_o(hedef),
    .g2_ps_i(g2_ps), .g2_guncelle_i(g2_gun), .g2_atladi_i(g2_atl),
    .g2_hatali_tahmin_i(g2_hat), .g2_hedef_i(g2_hedef),
    .sayac_guncelle_o(s_gun), .sayac_hatali_o(s_hat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin m_v[i] = 0; m_ctr[i] = 1; end
    e_g = 0; e_at = 0; e_ps = 0; e_hd = 0; e_cg = 0; e_ch = 0;
  endtask

  // Assert reset between edges and check the outputs before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_gecerli", {31'b0, gecerli}, 0);
    chk("rst_atla", {31'b0, atla}, 0);
    chk("rst_ps", ps_o, 0);
    chk("rst_hedef", hedef, 0);
    chk("rst_sayac_gun", s_gun, 0);
    chk("rst_sayac_hat", s_hat, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step(input bit ist, input logic [31:0] p, input bit st, input bit fl,
                      input bit up, input bit at, input bit ht,
                      input logic [31:0] ups, input logic [31:0] utg);
    int li, ui;
    bit hit;
    istek = ist; ps = p; durak = st; bosalt = fl;
    g2_gun = up; g2_atl = at; g2_hat = ht; g2_ps = ups; g2_hedef = utg;
    li = int'((p / 4) % 64);
    if (fl) e_g = 0;
    else if (!st) begin
      e_g = ist;
      if (ist) begin
        hit  = m_v[li] && (m_tag[li] == p / 256);
        e_at = hit && (m_ctr[li] >= 2);
        e_ps = p;
        e_hd = e_at ? m_tgt[li] : p + 4;
      end
    end
    if (up) begin
      e_cg++;
      if (ht) e_ch++;
      ui = int'((ups / 4) % 64);
      if (m_v[ui] && m_tag[ui] == ups / 256) begin
        if (at) begin
          if (m_ctr[ui] < 3) m_ctr[ui]++;
          m_tgt[ui] = utg;
        end else if (m_ctr[ui] > 0) m_ctr[ui]--;
      end else if (at) begin
        m_v[ui] = 1; m_tag[ui] = ups / 256; m_tgt[ui] = utg; m_ctr[ui] = 2;
      end
    end
    @(posedge clk); #1;
    chk("gecerli", {31'b0, gecerli}, {31'b0, e_g});
    chk("sayac_gun", s_gun, e_cg);
    chk("sayac_hat", s_hat, e_ch);
    if (e_g) begin
      chk("ps", ps_o, e_ps);
      chk("atla", {31'b0, atla}, {31'b0, e_at});
      chk("hedef", hedef, e_hd);
    end
  endtask

  task automatic look(input logic [31:0] p);
    step(1, p, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] p, input bit at, input logic [31:0] tg);
    step(0, 0, 0, 0, 1, at, 0, p, tg);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    // reset miss and allocation/saturation
    look(32'h100);
    chk("reset_miss_hedef", hedef, 32'h104);
    upd(32'h100, 1, 32'h200);
    look(32'h100);
    chk("alloc_atla", {31'b0, atla}, 1);
    chk("alloc_hedef", hedef, 32'h200);
    repeat (3) upd(32'h100, 1, 32'h200);
    repeat (2) upd(32'h100, 0, 0);
    look(32'h100);
    chk("sat_down_atla", {31'b0, atla}, 0);
    chk("sat_down_hedef", hedef, 32'h104);

    // aliasing at index 0
    upd(32'h100, 1, 32'h200);
    look(32'h200);
    chk("alias_hedef", hedef, 32'h204);
    upd(32'h200, 1, 32'h300);
    look(32'h100);
    chk("evict_atla", {31'b0, atla}, 0);
    look(32'h200);
    chk("alias_new_hedef", hedef, 32'h300);

    // stall and flush
    look(32'h100);
    step(1, 32'h444, 1, 0, 0, 0, 0, 0, 0);
    step(1, 32'h888, 1, 0, 0, 0, 0, 0, 0);
    step(0, 32'hccc, 1, 0, 0, 0, 0, 0, 0);
    chk("stall_ps", ps_o, 32'h100);
    step(1, 32'h100, 0, 1, 0, 0, 0, 0, 0);
    chk("flush_gecerli", {31'b0, gecerli}, 0);

    // same-cycle read/write at counter 01
    upd(32'h100, 1, 32'h500);
    upd(32'h100, 0, 0);
    step(1, 32'h100, 0, 0, 1, 1, 0, 32'h100, 32'h500);
    chk("rw_old_atla", {31'b0, atla}, 0);
    look(32'h100);
    chk("rw_new_atla", {31'b0, atla}, 1);

    // statistics then mid-cycle reset
    do_reset();
    for (int i = 0; i < 10; i++)
      step(1, 32'h40, 0, 0, 1, i[0], (i % 3 == 0 && i < 9), 32'h40 + 32'(i * 4), 32'h900);
    chk("stat_gun", s_gun, 10);
    chk("stat_hat", s_hat, 3);
    #2;
    do_reset();
    look(32'h40);
    chk("post_reset_atla", {31'b0, atla}, 0);

    // random traffic over a few indices and tags
    for (int n = 0; n < 600; n++) begin
      logic [31:0] lp, up_p;
      lp   = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      up_p = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      step($urandom_range(0, 3) != 0, lp, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
           up_p, $urandom & 32'hffff_fffc);
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
